load_store_unit: RTL and testbench

Load/store unit sitting between the execute stage and the word-organised data memory. It accepts one load or store request at a time over a valid/ready handshake, generates byte enables and lane-replicated store data, and drives the memory for exactly one cycle. Load data is returned in the 32-bit register format, sign- or zero-extended. Illegal `func3` codes and (optionally) misaligned addresses are reported as errors without touching memory.

---
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte-lane steering, sign/zero extension and single-cycle memory strobes.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        legal, misal, err_new;
  logic [1:0]  off_new;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [31:0] shifted;
  logic [31:0] fmt;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W];
  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign accept      = req_valid & req_ready;

  always_comb begin
    legal = 1'b0;
    case (req_func3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_we;
      default:                legal = 1'b0;
    endcase
  end

  assign misal = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign err_new = ~legal | misal;
  assign off_new = req_addr[1:0];
`else
  assign err_new = ~legal;
  // Without trapping, misaligned halves/words are silently aligned down.
  assign off_new = req_func3[1] ? 2'b00 :
                   req_func3[0] ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = 32'h0;
    if (req_we) begin
      case (req_func3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << off_new;
          wdata_new = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_new    = 4'b0011 << off_new;
          wdata_new = {2{req_wdata[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = err_new ? RESP : ISSUE;
      ISSUE:   state_nxt = we_q ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    fmt = mem_rdata;
    case (f3_q)
      3'b000:  fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  fmt = {24'h0, shifted[7:0]};
      3'b101:  fmt = {16'h0, shifted[15:0]};
      default: fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      f3_q       <= 3'h0;
      off_q      <= 2'h0;
      we_q       <= 1'b0;
    end else begin
      // Memory strobes live only for the one cycle spent in ISSUE.
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      if (accept) begin
        f3_q       <= req_func3;
        off_q      <= off_new;
        we_q       <= req_we;
        resp_rdata <= 32'h0;
        resp_err   <= err_new;
        if (!err_new) begin
          mem_read  <= ~req_we;
          mem_write <= req_we;
          mem_addr  <= req_addr[ADDR_W-1:2];
          mem_be    <= be_new;
          mem_wdata <= wdata_new;
        end
      end
      if (state == WAIT) resp_rdata <= fmt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a registered-read memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] rd_word;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Registered read: data appears only after a sampled read strobe.
  always @(posedge clk) mem_rdata <= mem_read ? rd_word : 32'h0BADF00D;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_word;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          kind;   // 0 none, 1 read, 2 write
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdw, logic err, logic [31:0] rdata, int lat, int kind,
                              logic [31:0] maddr, logic [3:0] be, logic [31:0] mwdata, int hold);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd_word = rdw;
    v.err = err; v.rdata = rdata; v.lat = lat; v.kind = kind; v.maddr = maddr;
    v.be = be; v.mwdata = mwdata; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n_rd, n_wr, lat;
    logic seen;
    logic [31:0] a, b, w;
    n_rd = 0; n_wr = 0; lat = 0; seen = 1'b0; a = 0; b = 0; w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_func3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; rd_word = v.rd_word; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (mem_read || mem_write) begin
        n_rd += int'(mem_read); n_wr += int'(mem_write);
        a = 32'(mem_addr); b = 32'(mem_be); w = mem_wdata;
      end
      if (resp_valid) begin
        seen = 1'b1; lat = n + 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk($sformatf("vec%0d latency", idx), lat, v.lat);
    if (seen) begin
      for (int h = 0; h < v.hold; h++) begin
        n_rd += int'(mem_read); n_wr += int'(mem_write);
        chk($sformatf("vec%0d resp_valid hold%0d", idx, h), 32'(resp_valid), 1);
        chk($sformatf("vec%0d req_ready hold%0d", idx, h), 32'(req_ready), 0);
        chk($sformatf("vec%0d resp_err hold%0d", idx, h), 32'(resp_err), 32'(v.err));
        chk($sformatf("vec%0d resp_rdata hold%0d", idx, h), resp_rdata, v.rdata);
        @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk($sformatf("vec%0d resp_valid after handshake", idx), 32'(resp_valid), 0);
      chk($sformatf("vec%0d req_ready after handshake", idx), 32'(req_ready), 1);
    end
    chk($sformatf("vec%0d read strobes", idx), n_rd, (v.kind == 1) ? 1 : 0);
    chk($sformatf("vec%0d write strobes", idx), n_wr, (v.kind == 2) ? 1 : 0);
    if (v.kind != 0) begin
      chk($sformatf("vec%0d mem_addr", idx), a, v.maddr);
      chk($sformatf("vec%0d mem_be", idx), b, 32'(v.be));
      chk($sformatf("vec%0d mem_wdata", idx), w, v.mwdata);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'h0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; rd_word = 32'h0;

    // we, f3, addr, wdata, rd_word, err, rdata, lat, kind, maddr, be, mwdata, hold
    vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0, 2, 2, 4, 4'hF, 32'hDEADBEEF, 1));
    vecs.push_back(mk(1, 3'b000, 32'h13, 32'h000000A5, 0, 0, 0, 2, 2, 4, 4'h8, 32'hA5A5A5A5, 1));
    vecs.push_back(mk(0, 3'b000, 32'h13, 0, 32'hA5000000, 0, 32'hFFFFFFA5, 3, 1, 4, 4'hF, 0, 1));
    vecs.push_back(mk(0, 3'b100, 32'h13, 0, 32'hA5000000, 0, 32'h000000A5, 3, 1, 4, 4'hF, 0, 1));
    vecs.push_back(mk(0, 3'b001, 32'h02, 0, 32'h80011234, 0, 32'hFFFF8001, 3, 1, 0, 4'hF, 0, 1));
    vecs.push_back(mk(0, 3'b101, 32'h02, 0, 32'h80011234, 0, 32'h00008001, 3, 1, 0, 4'hF, 0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h04, 0, 32'h12345678, 0, 32'h12345678, 3, 1, 1, 4'hF, 0, 1));
    vecs.push_back(mk(0, 3'b011, 32'h20, 0, 32'h11111111, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'b011, 32'h20, 32'h55555555, 0, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b110, 32'h20, 0, 32'h22222222, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'b100, 32'h20, 32'h66666666, 0, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'b001, 32'h0E, 32'h1234BEEF, 0, 0, 0, 2, 2, 3, 4'hC, 32'hBEEFBEEF, 1));
    vecs.push_back(mk(0, 3'b000, 32'h01, 0, 32'h00007F00, 0, 32'h0000007F, 3, 1, 0, 4'hF, 0, 1));
    vecs.push_back(mk(1, 3'b010, 32'h1F4, 32'h01020304, 0, 0, 0, 2, 2, 32'h3D, 4'hF, 32'h01020304, 1));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 3'b010, 32'h06, 0, 32'hCAFEF00D, 1, 0, 1, 0, 0, 0, 0, 5));
    vecs.push_back(mk(1, 3'b001, 32'h05, 32'h0000ABCD, 0, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b001, 32'h03, 0, 32'h12348765, 1, 0, 1, 0, 0, 0, 0, 1));
`else
    vecs.push_back(mk(0, 3'b010, 32'h06, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 3, 1, 1, 4'hF, 0, 5));
    vecs.push_back(mk(1, 3'b001, 32'h05, 32'h0000ABCD, 0, 0, 0, 2, 2, 1, 4'h3, 32'hABCDABCD, 1));
    vecs.push_back(mk(0, 3'b001, 32'h03, 0, 32'h12348765, 0, 32'h00001234, 3, 1, 0, 4'hF, 0, 1));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 1);
    chk("reset resp_valid", 32'(resp_valid), 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset resp_err", 32'(resp_err), 0);
    chk("reset mem strobes", {30'h0, mem_read, mem_write}, 0);
    chk("reset mem_addr", 32'(mem_addr), 0);
    chk("reset mem_be", 32'(mem_be), 0);
    chk("reset mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset while a load is waiting on memory data
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h08; rd_word = 32'h77777777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midreset req_ready", 32'(req_ready), 1);
    chk("midreset resp_valid", 32'(resp_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midreset quiet%0d", k), {29'h0, resp_valid, mem_read, ~req_ready}, 0);
    end
    resp_ready = 1'b0;

    // The unit must still work after the abandoned operation
    run_vec(99, mk(0, 3'b000, 32'h0A, 0, 32'h00800000, 0, 32'hFFFFFF80, 3, 1, 2, 4'hF, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
